// File: rtl/pulse_stretch.sv
// Stretches single-cycle trigger events into fixed-width high pulses separated by
// fixed low gaps, queueing events that arrive while a pulse is in progress.
module pulse_stretch #(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int PEND_BITS   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 trig,
  output logic                 out,
  output logic                 busy,
  output logic [PEND_BITS-1:0] pending,
  output logic                 drop
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TW         = $clog2(MAX_CYCLES) + 1;

  localparam logic [TW-1:0]        HIGH_LOAD = TW'(HIGH_CYCLES - 1);
  localparam logic [TW-1:0]        LOW_LOAD  = TW'(LOW_CYCLES - 1);
  localparam logic [PEND_BITS-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [TW-1:0]        timer, timer_next;
  logic [PEND_BITS-1:0] pending_next;
  logic                 drop_next;

  logic last_low;
  logic have_pend;
  logic trig_consumed;
  logic trig_queued;
  logic take_pend;

  always_comb begin
    state_next    = state;
    timer_next    = timer;
    pending_next  = pending;
    drop_next     = 1'b0;

    last_low      = (state == LOW) && (timer == '0);
    have_pend     = (pending != '0);
    take_pend     = last_low && have_pend;
    // A trigger starts a pulse directly only when nothing is queued ahead of it.
    trig_consumed = trig && ((state == IDLE) || (last_low && !have_pend));
    trig_queued   = trig && !trig_consumed;

    case (state)
      IDLE: begin
        timer_next = '0;
        if (trig) begin
          state_next = HIGH;
          timer_next = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (timer == '0) begin
          state_next = LOW;
          timer_next = LOW_LOAD;
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      LOW: begin
        if (timer == '0) begin
          if (have_pend || trig) begin
            state_next = HIGH;
            timer_next = HIGH_LOAD;
          end else begin
            state_next = IDLE;
            timer_next = '0;
          end
        end else begin
          timer_next = timer - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        timer_next = '0;
      end
    endcase

    // Simultaneous dequeue and enqueue leaves the count untouched, even when full.
    if (take_pend && !trig_queued) begin
      pending_next = pending - 1'b1;
    end else if (!take_pend && trig_queued) begin
      if (pending == PEND_MAX) begin
        drop_next = 1'b1;
      end else begin
        pending_next = pending + 1'b1;
      end
    end
  end

  // out and busy are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      timer   <= '0;
      pending <= '0;
      drop    <= 1'b0;
      out     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      timer   <= timer_next;
      pending <= pending_next;
      drop    <= drop_next;
      out     <= (state_next == HIGH);
      busy    <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: directed timing scenarios plus random trigger traffic,
// checked against a pulse-period countdown model on two parameterisations.
module tb_pulse_stretch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trig0, trig1;
  logic       out0, busy0, drop0, out1, busy1, drop1;
  logic [1:0] pend0, pend1;

  always #5 clk = ~clk;

  pulse_stretch #(.HIGH_CYCLES(4), .LOW_CYCLES(4), .PEND_BITS(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .trig(trig0),
    .out(out0), .busy(busy0), .pending(pend0), .drop(drop0)
  );

  pulse_stretch #(.HIGH_CYCLES(1), .LOW_CYCLES(1), .PEND_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .trig(trig1),
    .out(out1), .busy(busy1), .pending(pend1), .drop(drop1)
  );

  logic [4:0] got0, got1;
  assign got0 = {out0, busy0, pend0, drop0};
  assign got1 = {out1, busy1, pend1, drop1};

  int checks = 0;
  int passes = 0;

  // Model: m_pos counts down the remaining cycles of the current pulse period
  // (high part then low part); m_cnt is the number of queued events.
  int m_pos[2];
  int m_cnt[2];
  bit m_drop[2];
  int mh[2] = '{4, 1};
  int ml[2] = '{4, 1};
  localparam int PMAX = 3;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pos[i]  = 0;
      m_cnt[i]  = 0;
      m_drop[i] = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input bit t);
    bit d = 1'b0;
    if (m_pos[i] == 0) begin
      if (t) m_pos[i] = mh[i] + ml[i];
    end else if (m_pos[i] == 1) begin
      if (m_cnt[i] > 0) begin
        m_pos[i] = mh[i] + ml[i];
        if (!t) m_cnt[i] = m_cnt[i] - 1;
      end else if (t) begin
        m_pos[i] = mh[i] + ml[i];
      end else begin
        m_pos[i] = 0;
      end
    end else begin
      m_pos[i] = m_pos[i] - 1;
      if (t) begin
        if (m_cnt[i] == PMAX) d = 1'b1;
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    m_drop[i] = d;
  endtask

  function automatic logic [4:0] exp_vec(input int i);
    return {m_pos[i] > ml[i], m_pos[i] > 0, 2'(m_cnt[i]), m_drop[i]};
  endfunction

  task automatic tick(input bit t0, input bit t1);
    trig0 = t0;
    trig1 = t1;
    @(posedge clk);
    model_step(0, t0);
    model_step(1, t1);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    trig0 = 1'b0;
    trig1 = 1'b0;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({got0, got1} !== 10'b0) $display("FAIL reset_state cycle %0d got %b/%b want 0", k, got0, got1);
      else passes++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      checks++;
      if ({got0, got1} !== 10'b0) $display("FAIL idle_after_reset cycle %0d got %b/%b want 0", k, got0, got1);
      else passes++;
    end
  endtask

  task automatic test_single();
    logic [4:0] e;
    for (int k = 1; k <= 10; k++) begin
      tick(k == 1, 1'b0);
      e = {k <= 4, k <= 8, 2'b00, 1'b0};
      checks++;
      if (got0 !== e || got0 !== exp_vec(0)) $display("FAIL single k=%0d got %b want %b", k, got0, e);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] e;
    for (int k = 1; k <= 18; k++) begin
      tick(k == 1 || k == 3, 1'b0);
      e = {(k <= 4) || (k >= 9 && k <= 12), k <= 16, (k >= 3 && k <= 8) ? 2'b01 : 2'b00, 1'b0};
      checks++;
      if (got0 !== e || got0 !== exp_vec(0)) $display("FAIL back_to_back k=%0d got %b want %b", k, got0, e);
      else passes++;
    end
  endtask

  task automatic test_last_low();
    logic [4:0] e;
    for (int k = 1; k <= 18; k++) begin
      tick(k == 1 || k == 9, 1'b0);
      e = {(k <= 4) || (k >= 9 && k <= 12), k <= 16, 2'b00, 1'b0};
      checks++;
      if (got0 !== e || got0 !== exp_vec(0)) $display("FAIL last_low k=%0d got %b want %b", k, got0, e);
      else passes++;
    end
  endtask

  task automatic test_saturate();
    int   pulses = 0;
    logic prev_out = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      tick(k <= 5, 1'b0);
      if (out0 && !prev_out) pulses++;
      prev_out = out0;
      checks++;
      if (got0 !== exp_vec(0) || drop0 !== (k == 5) || (k == 4 && pend0 !== 2'd3))
        $display("FAIL saturate k=%0d got %b want %b", k, got0, exp_vec(0));
      else passes++;
    end
    checks++;
    if (pulses != 4 || pend0 !== 2'd0) $display("FAIL saturate_pulses got %0d pend %0d want 4 pend 0", pulses, pend0);
    else passes++;
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 3; k++) tick(1'b1, 1'b0);
    checks++;
    if (pend0 !== 2'd2 || out0 !== 1'b1) $display("FAIL pre_reset pend %0d out %b want 2 1", pend0, out0);
    else passes++;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({out0, busy0, pend0, drop0} !== 5'b0) $display("FAIL async_reset got %b want 00000", got0);
    else passes++;
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (got0 !== 5'b0) $display("FAIL post_reset_quiet k=%0d got %b want 00000", k, got0);
      else passes++;
    end
  endtask

  task automatic test_fast();
    int peak = 0;
    int pulses = 0;
    logic prev_out = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0, k <= 6);
      if (out1 && !prev_out) pulses++;
      prev_out = out1;
      if (int'(pend1) > peak) peak = int'(pend1);
      checks++;
      if (got1 !== exp_vec(1) || out1 !== ((k % 2 == 1) && k <= 11) || drop1 !== 1'b0)
        $display("FAIL fast k=%0d got %b want %b", k, got1, exp_vec(1));
      else passes++;
    end
    checks++;
    if (pulses != 6 || peak != 3) $display("FAIL fast_summary pulses %0d peak %0d want 6 3", pulses, peak);
    else passes++;
  endtask

  task automatic test_random();
    int bad = 0;
    int density;
    bit t0, t1;
    for (int n = 0; n < 1500; n++) begin
      if (n % 300 == 0) density = $urandom_range(10, 90);
      if (n % 500 == 250) begin
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        t0 = 1'b1;
        t1 = 1'b1;
      end else begin
        t0 = ($urandom_range(0, 99) < density);
        t1 = ($urandom_range(0, 99) < density);
      end
      tick(t0, t1);
      checks++;
      if (got0 !== exp_vec(0) || got1 !== exp_vec(1)) begin
        bad++;
        if (bad <= 10) $display("FAIL random n=%0d got %b/%b want %b/%b", n, got0, got1, exp_vec(0), exp_vec(1));
      end else passes++;
    end
    for (int k = 0; k < 60; k++) tick(1'b0, 1'b0);
    checks++;
    if ({got0, got1} !== 10'b0 || {got0, got1} !== {exp_vec(0), exp_vec(1)})
      $display("FAIL random_drain got %b/%b want 0", got0, got1);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    tick(1'b0, 1'b0);
    test_back_to_back();
    tick(1'b0, 1'b0);
    test_last_low();
    tick(1'b0, 1'b0);
    test_saturate();
    test_reset_mid();
    test_fast();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
